// File: rtl/prog_ctr_stack.sv
// rtl/prog_ctr_stack.sv - program counter with relative branch, jump and hardware return-address stack
module prog_ctr_stack #(
  parameter int              W        = 8,
  parameter int              DEPTH    = 4,
  parameter logic [W-1:0]    RESET_PC = '0,
  localparam int             SPW      = $clog2(DEPTH + 1)
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Stall,
  input  logic [2:0]     Op,
  input  logic           Zero,
  input  logic [W-1:0]   Target,
  output logic [W-1:0]   PC,
  output logic [SPW-1:0] SP,
  output logic           StackFull,
  output logic           StackEmpty,
  output logic           StackErr
);

  localparam int             AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_BRZ  = 3'b001,
    OP_BRNZ = 3'b010,
    OP_JMP  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101
  } op_t;

  logic [W-1:0]   stack_mem [DEPTH];
  logic [W-1:0]   pc_plus1;
  logic [W-1:0]   pc_rel;
  logic [W-1:0]   pc_next;
  logic [SPW-1:0] sp_next;
  logic           push;
  logic           err_set;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;

  assign pc_plus1   = PC + W'(1);
  // Two's-complement add of the offset wraps modulo 2^W in both directions.
  assign pc_rel     = PC + Target;
  assign wr_idx     = AW'(SP);
  assign rd_idx     = AW'(SP - SPW'(1));
  assign StackFull  = (SP == SP_MAX);
  assign StackEmpty = (SP == '0);

  always_comb begin
    pc_next = pc_plus1;
    sp_next = SP;
    push    = 1'b0;
    err_set = 1'b0;
    case (Op)
      OP_BRZ:  pc_next = Zero ? pc_rel : pc_plus1;
      OP_BRNZ: pc_next = Zero ? pc_plus1 : pc_rel;
      OP_JMP:  pc_next = Target;
      OP_CALL: begin
        if (StackFull) begin
          err_set = 1'b1;
        end else begin
          push    = 1'b1;
          sp_next = SP + SPW'(1);
          pc_next = Target;
        end
      end
      OP_RET: begin
        if (StackEmpty) begin
          err_set = 1'b1;
        end else begin
          sp_next = SP - SPW'(1);
          pc_next = stack_mem[rd_idx];
        end
      end
      default: pc_next = pc_plus1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      PC       <= RESET_PC;
      SP       <= '0;
      StackErr <= 1'b0;
    end else if (!Stall) begin
      PC       <= pc_next;
      SP       <= sp_next;
      StackErr <= StackErr | err_set;
    end
  end

  // Stack storage carries no reset; entries above SP are never read.
  always_ff @(posedge Clk) begin
    if (Reset_n && !Stall && push) begin
      stack_mem[wr_idx] <= pc_plus1;
    end
  end

endmodule
